// File: rtl/cpu_pkg.sv
// Shared CPU fetch-stage definitions: address width, reset/trap vectors,
// address type and the next-pc source select encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_VEC = 32'h0000_0000;
  localparam addr_t TRAP_VEC  = 32'h0000_0100;

  // Next-pc source, listed in priority order (highest first)
  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_RET,
    SEL_UFLOW,
    SEL_HOLD,
    SEL_SEQ
  } next_pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at wp, advance wp (oldest entry lost when full)
//   push_data   return address to store
//   pop         read top entry, retreat wp (caller guarantees non-empty)
//   top         entry at wp-1 (combinational read of registered storage)
//   count       valid entries (registered)
//   empty       count == 0
module pc_ras
  import cpu_pkg::*;
#(
  parameter int unsigned W     = ADDR_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [W-1:0]                   push_data,
  input  logic                           pop,
  output logic [W-1:0]                   top,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally
  assign rd_ptr = wp_q - PTR_W'(1);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign top    = mem_q[rd_ptr];
  assign count  = count_q;

  // Pointer / count / storage next-state
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    count_d = count_q;
    if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = wp_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop) begin
      wp_d    = rd_ptr;
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Storage contents are don't-care after reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with trap vectoring, aligned redirects and a
// return-address stack for call/return.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall           hold pc (only blocks sequential advance)
//   redirect        taken branch/jump to redirect_addr (aligned to INC)
//   redirect_addr   branch/jump target
//   call            with redirect: push pc_plus onto the RAS
//   ret             pop RAS and jump; empty pop vectors to TRAP_VEC
//   trap            jump to TRAP_VEC, everything else ignored
//   pc              current fetch address (registered)
//   pc_plus         pc + INC (combinational)
//   ras_count       valid RAS entries (registered)
//   ras_underflow   one-cycle pulse after an empty pop (registered)
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W    = cpu_pkg::ADDR_W,
  parameter int unsigned        INC       = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(cpu_pkg::RESET_VEC),
  parameter logic [ADDR_W-1:0]  TRAP_VEC  = ADDR_W'(cpu_pkg::TRAP_VEC),
  parameter int unsigned        RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             redirect,
  input  logic [ADDR_W-1:0]                redirect_addr,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             trap,
  output logic [ADDR_W-1:0]                pc,
  output logic [ADDR_W-1:0]                pc_plus,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ras_underflow_q, ras_underflow_d;
  next_pc_sel_e      sel;
  logic              ras_push, ras_pop, ras_empty;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] redir_aligned;

  assign pc_plus       = pc_q + ADDR_W'(INC);
  // INC is a power of two: clear the sub-instruction address bits
  assign redir_aligned = redirect_addr & ~ADDR_W'(INC - 1);

  // Next-pc source priority
  always_comb begin
    sel = SEL_SEQ;
    if (trap)                  sel = SEL_TRAP;
    else if (redirect)         sel = SEL_REDIR;
    else if (ret && !ras_empty) sel = SEL_RET;
    else if (ret)              sel = SEL_UFLOW;
    else if (stall)            sel = SEL_HOLD;
  end

  assign ras_push = (sel == SEL_REDIR) && call;
  assign ras_pop  = (sel == SEL_RET);

  // Next pc and underflow flag
  always_comb begin
    pc_d            = pc_plus;
    ras_underflow_d = 1'b0;
    case (sel)
      SEL_TRAP:  pc_d = TRAP_VEC;
      SEL_REDIR: pc_d = redir_aligned;
      SEL_RET:   pc_d = ras_top;
      SEL_UFLOW: begin
        pc_d            = TRAP_VEC;
        ras_underflow_d = 1'b1;
      end
      SEL_HOLD:  pc_d = pc_q;
      default:   pc_d = pc_plus;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q            <= RESET_VEC;
      ras_underflow_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ras_underflow_q <= ras_underflow_d;
    end
  end

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .push_data (pc_plus),
    .pop       (ras_pop),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty)
  );

  assign pc            = pc_q;
  assign ras_underflow = ras_underflow_q;

endmodule
